// File: rtl/chan_mux_scan.sv
// Registered NUM_CH-way channel mux with manual select and dwell-timed auto-scan.
// Define CHAN_MUX_MASK_EN to add the ch_mask port (per-channel enable, scan skips masked channels).
module chan_mux_scan #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 1,
  parameter int DWELL  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*DATA_W-1:0]   i,
  input  logic [$clog2(NUM_CH)-1:0]  s,
  input  logic                       mode,
  input  logic                       en,
`ifdef CHAN_MUX_MASK_EN
  input  logic [NUM_CH-1:0]          ch_mask,
`endif
  output logic [DATA_W-1:0]          y,
  output logic                       y_valid,
  output logic [$clog2(NUM_CH)-1:0]  cur_sel,
  output logic                       wrap
);

  localparam int SEL_W = $clog2(NUM_CH);
  localparam int DW_W  = $clog2(DWELL + 1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);

  logic [SEL_W-1:0]  r_ptr;
  logic [DW_W-1:0]   r_dwell;
  logic [DATA_W-1:0] r_y;
  logic              r_y_valid;
  logic [SEL_W-1:0]  r_cur_sel;
  logic              r_wrap;

  logic [NUM_CH-1:0] w_mask;
  logic [SEL_W-1:0]  w_sel;
  logic [DATA_W-1:0] w_data;
  logic              w_hit;
  logic              w_dwell_done;
  logic [SEL_W-1:0]  w_ptr_next;
  logic              w_ptr_wraps;

`ifdef CHAN_MUX_MASK_EN
  assign w_mask = ch_mask;
`else
  assign w_mask = {NUM_CH{1'b1}};
`endif

  // Index base+k modulo NUM_CH using an explicit compare rather than counter overflow.
  function automatic int ring_add(input int base, input int k);
    int sum;
    sum = base + k;
    if (sum >= NUM_CH) begin
      return sum - NUM_CH;
    end else begin
      return sum;
    end
  endfunction

  // Channel select: out-of-range or masked selections yield zero data and no valid.
  always_comb begin
    w_sel  = mode ? r_ptr : s;
    w_data = {DATA_W{1'b0}};
    w_hit  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_data = w_data | ({DATA_W{(w_sel == SEL_W'(k)) && w_mask[k]}} & i[k*DATA_W +: DATA_W]);
      w_hit  = w_hit | ((w_sel == SEL_W'(k)) && w_mask[k]);
    end
  end

  // Next enabled channel after the pointer; descending scan lets the nearest one win.
  always_comb begin
    w_ptr_next   = r_ptr;
    w_ptr_wraps  = 1'b0;
    w_dwell_done = (r_dwell == DW_LAST);
    for (int k = NUM_CH; k >= 1; k--) begin
      w_ptr_next  = w_mask[SEL_W'(ring_add(int'(r_ptr), k))] ?
                    SEL_W'(ring_add(int'(r_ptr), k)) : w_ptr_next;
      w_ptr_wraps = w_mask[SEL_W'(ring_add(int'(r_ptr), k))] ?
                    ((int'(r_ptr) + k) >= NUM_CH) : w_ptr_wraps;
    end
  end

  // Output, pointer and dwell registers; en=0 freezes everything but drops a pending wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= {SEL_W{1'b0}};
      r_dwell   <= {DW_W{1'b0}};
      r_y       <= {DATA_W{1'b0}};
      r_y_valid <= 1'b0;
      r_cur_sel <= {SEL_W{1'b0}};
      r_wrap    <= 1'b0;
    end else if (en) begin
      r_y       <= w_data;
      r_y_valid <= w_hit;
      r_cur_sel <= w_sel;
      if (mode) begin
        if (w_dwell_done) begin
          r_dwell <= {DW_W{1'b0}};
          r_ptr   <= w_ptr_next;
          r_wrap  <= w_ptr_wraps;
        end else begin
          r_dwell <= r_dwell + DW_W'(1);
          r_wrap  <= 1'b0;
        end
      end else begin
        // An illegal manual index parks the scan pointer on channel 0.
        r_ptr   <= (int'(s) < NUM_CH) ? s : {SEL_W{1'b0}};
        r_dwell <= {DW_W{1'b0}};
        r_wrap  <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign y       = r_y;
  assign y_valid = r_y_valid;
  assign cur_sel = r_cur_sel;
  assign wrap    = r_wrap & en;

endmodule

// File: tb/tb_chan_mux_scan.sv
// Scoreboard bench for chan_mux_scan: 8x1/dwell 4, 5x4/dwell 4 and 8x1/dwell 1 instances.
// Mask scenarios run only when CHAN_MUX_MASK_EN is defined.
module tb_chan_mux_scan;

  logic        clk = 1'b0;
  logic        rst, en, mode;
  logic [7:0]  i8, i1;
  logic [19:0] i5;
  logic [2:0]  s8, s5, s1;
  logic        y8, y1;
  logic [3:0]  y5;
  logic        v8, v5, v1, w8, w5, w1;
  logic [2:0]  cs8, cs5, cs1;
`ifdef CHAN_MUX_MASK_EN
  logic [7:0]  ch_mask;
`endif

  always #5 clk = ~clk;

  chan_mux_scan #(.NUM_CH(8), .DATA_W(1), .DWELL(4)) u_dut8 (
    .clk(clk), .rst(rst), .i(i8), .s(s8), .mode(mode), .en(en),
`ifdef CHAN_MUX_MASK_EN
    .ch_mask(8'hFF),
`endif
    .y(y8), .y_valid(v8), .cur_sel(cs8), .wrap(w8));

  chan_mux_scan #(.NUM_CH(5), .DATA_W(4), .DWELL(4)) u_dut5 (
    .clk(clk), .rst(rst), .i(i5), .s(s5), .mode(mode), .en(en),
`ifdef CHAN_MUX_MASK_EN
    .ch_mask(5'h1F),
`endif
    .y(y5), .y_valid(v5), .cur_sel(cs5), .wrap(w5));

  chan_mux_scan #(.NUM_CH(8), .DATA_W(1), .DWELL(1)) u_dut1 (
    .clk(clk), .rst(rst), .i(i1), .s(s1), .mode(mode), .en(en),
`ifdef CHAN_MUX_MASK_EN
    .ch_mask(ch_mask),
`endif
    .y(y1), .y_valid(v1), .cur_sel(cs1), .wrap(w1));

  typedef struct {
    int         dut;
    string      tag;
    logic [8:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  function automatic logic [3:0] bit_of(input logic [7:0] v, input int p);
    logic [7:0] t;
    t = v >> p;
    return {3'b000, t[0]};
  endfunction

  function automatic logic [3:0] nib_of(input logic [19:0] v, input int p);
    logic [19:0] t;
    t = v >> (4 * p);
    return t[3:0];
  endfunction

  task automatic expect_out(input int dut, input string tag, input logic [3:0] ey,
                            input logic ev, input logic [2:0] ecs, input logic ew);
    exp_t e;
    e.dut = dut;
    e.tag = tag;
    e.val = {ey, ev, ecs, ew};
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t       e;
    logic [8:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.dut)
        8:       obs = {3'b000, y8, v8, cs8, w8};
        5:       obs = {y5, v5, cs5, w5};
        default: obs = {3'b000, y1, v1, cs1, w1};
      endcase
      n_total++;
      assert (obs === e.val) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s dut%0d: y/valid/sel/wrap got %h/%b/%0d/%b want %h/%b/%0d/%b",
               e.tag, e.dut, obs[8:5], obs[4], obs[3:1], obs[0],
               e.val[8:5], e.val[4], e.val[3:1], e.val[0]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic expect_zero_all(input string tag);
    expect_out(8, tag, 4'h0, 1'b0, 3'd0, 1'b0);
    expect_out(5, tag, 4'h0, 1'b0, 3'd0, 1'b0);
    expect_out(1, tag, 4'h0, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 1'b0;
    i8 = 8'h00; i5 = 20'h0; i1 = 8'h00;
    s8 = 3'd0; s5 = 3'd0; s1 = 3'd0;
`ifdef CHAN_MUX_MASK_EN
    ch_mask = 8'hFF;
`endif
    expect_zero_all("reset_state");
    tick();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Manual one-hot walk, then a mixed pattern, on the 8-channel instance.
    for (int k = 0; k < 8; k++) begin
      i8 = 8'h01 << k;
      s8 = 3'(k);
      expect_out(8, "manual_onehot", 4'h1, 1'b1, 3'(k), 1'b0);
      tick();
    end
    i8 = 8'h5A;
    for (int k = 0; k < 8; k++) begin
      s8 = 3'(k);
      expect_out(8, "manual_pattern", bit_of(8'h5A, k), 1'b1, 3'(k), 1'b0);
      tick();
    end

    // Non-power-of-2 instance: illegal selects give zero/invalid with cur_sel echoed.
    i5 = 20'h973C1;
    s5 = 3'd6; expect_out(5, "oob_sel6", 4'h0, 1'b0, 3'd6, 1'b0); tick();
    s5 = 3'd4; expect_out(5, "last_ch4", 4'h9, 1'b1, 3'd4, 1'b0); tick();
    s5 = 3'd7; expect_out(5, "oob_sel7", 4'h0, 1'b0, 3'd7, 1'b0); tick();
    s5 = 3'd5; expect_out(5, "oob_sel5", 4'h0, 1'b0, 3'd5, 1'b0); tick();
    s5 = 3'd1; expect_out(5, "ch1",      4'hC, 1'b1, 3'd1, 1'b0); tick();
    s5 = 3'd0; expect_out(5, "ch0",      4'h1, 1'b1, 3'd0, 1'b0); tick();

    // Full scan from reset on all three instances.
    i8 = 8'hA5; i1 = 8'h3C; s8 = 3'd0; s1 = 3'd0; s5 = 3'd0;
    mode = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 36; n++) begin
      expect_out(8, "scan8", bit_of(8'hA5, (n / 4) % 8), 1'b1, 3'((n / 4) % 8), (n % 32) == 31);
      expect_out(5, "scan5", nib_of(20'h973C1, (n / 4) % 5), 1'b1, 3'((n / 4) % 5), (n % 20) == 19);
      expect_out(1, "scan_dwell1", bit_of(8'h3C, n % 8), 1'b1, 3'(n % 8), (n % 8) == 7);
      tick();
    end

    // Scan -> manual switches on the next edge; manual -> scan starts at the last s.
    mode = 1'b0; s8 = 3'd5; s1 = 3'd2;
    expect_out(8, "to_manual", 4'h1, 1'b1, 3'd5, 1'b0);
    expect_out(1, "to_manual", 4'h1, 1'b1, 3'd2, 1'b0);
    tick();
    mode = 1'b1;
    for (int k = 0; k < 5; k++) begin
      expect_out(8, "to_scan", bit_of(8'hA5, (k < 4) ? 5 : 6), 1'b1, (k < 4) ? 3'd5 : 3'd6, 1'b0);
      expect_out(1, "to_scan", bit_of(8'h3C, 2 + k), 1'b1, 3'(2 + k), 1'b0);
      tick();
    end

    // Freeze mid-dwell (dut8 at ch3 dwell 2) and while a wrap pulse is showing (dut1).
    mode = 1'b0; s8 = 3'd3; s1 = 3'd6;
    expect_out(8, "pause_setup", 4'h0, 1'b1, 3'd3, 1'b0);
    expect_out(1, "pause_setup", 4'h0, 1'b1, 3'd6, 1'b0);
    tick();
    mode = 1'b1;
    expect_out(8, "pause_dw0", 4'h0, 1'b1, 3'd3, 1'b0);
    expect_out(1, "pause_p6",  4'h0, 1'b1, 3'd6, 1'b0);
    tick();
    expect_out(8, "pause_dw1", 4'h0, 1'b1, 3'd3, 1'b0);
    expect_out(1, "pause_wrap", 4'h0, 1'b1, 3'd7, 1'b1);
    tick();
    en = 1'b0;
    #1;
    expect_out(1, "wrap_gated", 4'h0, 1'b1, 3'd7, 1'b0);
    check_all();
    i8 = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      expect_out(8, "frozen", 4'h0, 1'b1, 3'd3, 1'b0);
      expect_out(1, "frozen", 4'h0, 1'b1, 3'd7, 1'b0);
      tick();
    end
    en = 1'b1;
    expect_out(8, "resume_dw2", 4'h1, 1'b1, 3'd3, 1'b0);
    expect_out(1, "resume", 4'h0, 1'b1, 3'd0, 1'b0);
    tick();
    expect_out(8, "resume_dw3", 4'h1, 1'b1, 3'd3, 1'b0);
    expect_out(1, "resume", 4'h0, 1'b1, 3'd1, 1'b0);
    tick();
    expect_out(8, "resume_adv", 4'h1, 1'b1, 3'd4, 1'b0);
    expect_out(1, "resume", 4'h1, 1'b1, 3'd2, 1'b0);
    tick();

    // Asynchronous reset mid-dwell at pointer 6, then restart from channel 0.
    i8 = 8'hA5; s8 = 3'd0; rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 26; n++) begin
      expect_out(8, "pre_rst_scan", bit_of(8'hA5, n / 4), 1'b1, 3'(n / 4), 1'b0);
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    expect_zero_all("async_rst");
    check_all();
    @(posedge clk);
    #1;
    expect_zero_all("rst_held");
    check_all();
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      expect_out(8, "post_rst_scan", bit_of(8'hA5, n / 4), 1'b1, 3'(n / 4), 1'b0);
      tick();
    end

`ifdef CHAN_MUX_MASK_EN
    // Masked scan skips disabled channels; empty mask holds the pointer invalid.
    rst = 1'b1; ch_mask = 8'b1000_0101; i1 = 8'hFF; s1 = 3'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_out(1, "mask_scan", 4'h1, 1'b1, 3'd0, 1'b0); tick();
    expect_out(1, "mask_scan", 4'h1, 1'b1, 3'd2, 1'b0); tick();
    expect_out(1, "mask_wrap", 4'h1, 1'b1, 3'd7, 1'b1); tick();
    expect_out(1, "mask_scan", 4'h1, 1'b1, 3'd0, 1'b0); tick();
    expect_out(1, "mask_scan", 4'h1, 1'b1, 3'd2, 1'b0); tick();
    ch_mask = 8'h00;
    expect_out(1, "mask_none", 4'h0, 1'b0, 3'd7, 1'b0); tick();
    expect_out(1, "mask_hold", 4'h0, 1'b0, 3'd7, 1'b0); tick();
    mode = 1'b0; ch_mask = 8'b0000_0101; s1 = 3'd1;
    expect_out(1, "mask_manual_off", 4'h0, 1'b0, 3'd1, 1'b0); tick();
    s1 = 3'd2;
    expect_out(1, "mask_manual_on", 4'h1, 1'b1, 3'd2, 1'b0); tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
